// File: rtl/et_ctrl_if.sv
// -----------------------------------------------------------------------------
// et_ctrl_if
// Bundles the signals between the early-termination sequencer and its
// neighbours: request side (start/prec/start_ready), stream side
// (z_in/et_req/z_out/sng_en/rshift/cnt_clr) and result side
// (done_valid/done_ready/res_prec/res_len).
//   slave  : view taken by et_ctrl
//   master : view taken by the requester / testbench
// -----------------------------------------------------------------------------
interface et_ctrl_if #(
    parameter int MAX_P = 8,
    parameter int P_W   = $clog2(MAX_P + 1)
) ();
    logic             start;
    logic [P_W-1:0]   prec;
    logic             start_ready;
    logic             z_in;
    logic             et_req;
    logic             z_out;
    logic             sng_en;
    logic             rshift;
    logic             cnt_clr;
    logic             done_valid;
    logic             done_ready;
    logic [P_W-1:0]   res_prec;
    logic [MAX_P:0]   res_len;

    modport slave (
        input  start, prec, z_in, et_req, done_ready,
        output start_ready, z_out, sng_en, rshift, cnt_clr,
               done_valid, res_prec, res_len
    );

    modport master (
        output start, prec, z_in, et_req, done_ready,
        input  start_ready, z_out, sng_en, rshift, cnt_clr,
               done_valid, res_prec, res_len
    );
endinterface

// File: rtl/et_ctrl.sv
// -----------------------------------------------------------------------------
// et_ctrl
// Early-termination sequencer for the variable-shift binary counter.
// Accepts a conversion request with a target precision p, clears the counter
// for one cycle, then gates the stochastic stream into it for up to 2^p
// cycles, pulsing rshift at every power-of-two stream length >= 2. Stops at
// 2^p or, on an early-termination request, at the next power-of-two boundary,
// and presents the achieved precision/length on a valid/ready handshake.
//
// Ports
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : et_ctrl_if.slave
//            start/prec/start_ready       request handshake
//            z_in/et_req                  stream bit, early-term request
//            z_out/sng_en/rshift/cnt_clr  counter control
//            done_valid/done_ready        result handshake
//            res_prec/res_len             achieved precision j, length 2^j
//
// Build option
//   ET_CTRL_EARLY_TERM_EN : when defined, et_req/et_pend terminate the run at
//                           the next boundary; otherwise every run is 2^p long.
// -----------------------------------------------------------------------------
module et_ctrl #(
    parameter int MAX_P = 8,
    parameter int P_W   = $clog2(MAX_P + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    et_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [P_W-1:0]   r_p;
    logic [MAX_P:0]   r_i;
    logic [P_W-1:0]   r_res_prec;
    logic [MAX_P:0]   r_res_len;

    logic [MAX_P:0]   w_ip1;
    logic [MAX_P:0]   w_pow;
    logic             w_boundary;
    logic [P_W-1:0]   w_j;
    logic             w_et_now;
    logic             w_exit;
    logic [P_W-1:0]   w_prec_clamped;

    // i+1 never exceeds 2^MAX_P, so it fits in MAX_P+1 bits without wrap.
    assign w_ip1 = r_i + {{MAX_P{1'b0}}, 1'b1};

    // w_pow[gi] marks i+1 == 2^gi; at most one bit can be set.
    generate
        for (genvar gi = 0; gi <= MAX_P; gi++) begin : g_pow
            localparam logic [MAX_P:0] L_BIT = {{MAX_P{1'b0}}, 1'b1} << gi;
            assign w_pow[gi] = (w_ip1 == L_BIT);
        end
    endgenerate

    assign w_boundary = |w_pow;

    always_comb begin
        w_j = '0;
        for (int k = 0; k <= MAX_P; k++) begin
            if (w_pow[k]) w_j = P_W'(k);
        end
    end

`ifdef ET_CTRL_EARLY_TERM_EN
    logic r_et_pend;
    // A request in the boundary cycle itself counts without waiting for et_pend.
    assign w_et_now = r_et_pend | bus.et_req;
`else
    assign w_et_now = 1'b0;
`endif

    // i never runs past 2^p-1, so a boundary always has j <= p.
    assign w_exit = (r_state == S_RUN) && w_boundary &&
                    ((w_j == r_p) || w_et_now);

    assign w_prec_clamped = (bus.prec > P_W'(MAX_P)) ? P_W'(MAX_P) : bus.prec;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)      w_state_next = S_CLR;
            S_CLR:                       w_state_next = S_RUN;
            S_RUN:   if (w_exit)         w_state_next = S_DONE;
            S_DONE:  if (bus.done_ready) w_state_next = S_IDLE;
            default:                     w_state_next = S_IDLE;
        endcase
    end

    // Cycle index, latched precision, results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p        <= '0;
            r_i        <= '0;
            r_res_prec <= '0;
            r_res_len  <= '0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_p <= w_prec_clamped;
                r_i <= '0;
            end
            if (r_state == S_RUN) begin
                if (w_exit) begin
                    r_res_prec <= w_j;
                    r_res_len  <= w_ip1;   // equals 2^j on a boundary
                end else begin
                    r_i <= w_ip1;
                end
            end
        end
    end

`ifdef ET_CTRL_EARLY_TERM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_et_pend <= 1'b0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_et_pend <= 1'b0;
        end else if (r_state == S_RUN && !w_boundary && bus.et_req) begin
            r_et_pend <= 1'b1;
        end
    end
`endif

    // Moore outputs; z_out is the only combinational path from an input.
    assign bus.start_ready = (r_state == S_IDLE);
    assign bus.cnt_clr     = (r_state == S_CLR);
    assign bus.sng_en      = (r_state == S_RUN);
    assign bus.rshift      = (r_state == S_RUN) && w_boundary && (r_i != '0);
    assign bus.z_out       = bus.z_in & bus.sng_en;
    assign bus.done_valid  = (r_state == S_DONE);
    assign bus.res_prec    = r_res_prec;
    assign bus.res_len     = r_res_len;

endmodule
